// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit MEM-stage loads/stores into two 16-bit async SRAM accesses.
`timescale 1ns/1ps
module sram_controller #(
  parameter int WAIT_CYCLES = 5,
  parameter int SRAM_AW = 18,
  parameter int BASE_ADDR = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);
  localparam int CW = $clog2(WAIT_CYCLES);
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic last, hi, wr_st, rd_st;
  logic [SRAM_AW-2:0] idx;
  assign last = cnt_q == CW'(WAIT_CYCLES - 1);
  assign wr_st = state_q == WR_LO || state_q == WR_HI;
  assign rd_st = state_q == RD_LO || state_q == RD_HI;
  assign hi = state_q == WR_HI || state_q == RD_HI;
  // Word index truncated to the SRAM width; out-of-range addresses wrap by design.
  assign idx = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE:  state_d = wr_en ? WR_LO : rd_en ? RD_LO : IDLE;
      WR_LO: state_d = last ? WR_HI : WR_LO;
      WR_HI: state_d = last ? DONE : WR_HI;
      RD_LO: if (last) begin
        state_d = RD_HI;
        rdata_d[15:0] = SRAM_DQ;
      end
      RD_HI: if (last) begin
        state_d = DONE;
        rdata_d[31:16] = SRAM_DQ;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
    end
  // The last cycle of each write half releases WE_N while data is still driven.
  assign SRAM_WE_N = !(wr_st && !last);
  assign SRAM_OE_N = !rd_st;
  assign SRAM_ADDR = (wr_st || rd_st) ? {idx, hi} : '0;
  assign SRAM_DQ = wr_st ? (hi ? write_data[31:16] : write_data[15:0]) : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign ready = (state_q == IDLE && !wr_en && !rd_en) || state_q == DONE;
  assign read_data = rdata_q;
endmodule
